// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   ALUControl codes used by the ALU and by div_unit to pick the operation.
//   Divider FSM state type, plus a helper that recognises divide opcodes.
package cpu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_REM  = 4'b1101;
    localparam logic [3:0] ALU_REMU = 4'b1110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    function automatic logic is_div_op(input logic [3:0] code);
        return (code == ALU_DIV) || (code == ALU_DIVU) ||
               (code == ALU_REM) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   rem, quo  : current partial remainder and dividend/quotient shift register
//   divisor   : divisor magnitude
//   rem_next, quo_next : values after shifting {rem,quo} left and trial-subtracting
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            take;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        take    = (shifted >= {1'b0, divisor});
        // When take is set the true difference is below divisor, so the
        // low XLEN bits of the subtraction are exact.
        diff    = shifted[XLEN-1:0] - divisor;
        rem_next = take ? diff : shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle iterative divider for DIV/DIVU/REM/REMU.
//   clk, reset : clock, asynchronous active-high reset
//   start, op  : one-cycle request and ALUControl code (accepted only in IDLE)
//   a, b       : dividend, divisor
//   flush      : abort any in-flight operation (beats a same-cycle start)
//   busy       : high while an accepted operation is in flight, through done
//   done       : one-cycle pulse, result valid
//   result     : quotient or remainder, held until the next completion
module div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    div_state_t state, state_next;

    logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
    logic [XLEN-1:0]  rem_step, quo_step;
    logic [CNT_W-1:0] cnt;
    logic             op_rem, q_neg, r_neg;

    logic            accept, sgn, is_rem, a_neg, b_neg, special;
    logic [XLEN-1:0] a_mag, b_mag, spec_quo, spec_rem, fix_quo, fix_rem;

    always_comb begin
        accept   = (state == DIV_IDLE) && start && is_div_op(op) && !flush;
        sgn      = (op == ALU_DIV) || (op == ALU_REM);
        is_rem   = (op == ALU_REM) || (op == ALU_REMU);
        a_neg    = sgn && a[XLEN-1];
        b_neg    = sgn && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        special  = (b == '0) || (sgn && (a == MIN_NEG) && (b == '1));
        spec_quo = (b == '0) ? '1 : MIN_NEG;
        spec_rem = (b == '0) ? a  : '0;
        fix_quo  = q_neg ? -quo_q : quo_q;
        fix_rem  = r_neg ? -rem_q : rem_q;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = DIV_IDLE;
        end else begin
            unique case (state)
                DIV_IDLE: if (accept) state_next = special ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (cnt == LAST_ITER) state_next = DIV_FIX;
                DIV_FIX:  state_next = DIV_DONE;
                DIV_DONE: state_next = DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state != DIV_IDLE);
        done = (state == DIV_DONE);
    end

    // Datapath; result is only written on the way into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt    <= '0;
            op_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvsr_q <= b_mag;
            cnt    <= '0;
            op_rem <= is_rem;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            if (special) result <= is_rem ? spec_rem : spec_quo;
        end else if (!flush && state == DIV_CALC) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + CNT_W'(1);
        end else if (!flush && state == DIV_FIX) begin
            result <= op_rem ? fix_rem : fix_quo;
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the combinational ALU. Takes the same A/B operands and ALUControl code from decode/operand select.
- Drives the result-select mux feeding register writeback.
- Provides a busy signal that stalls PC and writeback until the quotient or remainder is ready, so the ALU's single-cycle divide path can be retired.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- op  input  4  ALUControl code: 1011 DIV, 1100 DIVU, 1101 REM, 1110 REMU.
- a  input  XLEN  dividend.
- b  input  XLEN  divisor.
- flush  input  1  abort in-flight operation.
- busy  output  1  high from the cycle after accepted start until done cycle inclusive; core stalls on busy.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder per op; held until next accepted start.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-high. On reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States:
  - IDLE: wait for start.
  - CALC: XLEN restoring-division iterations.
  - FIX: apply signs.
  - DONE: done=1 for one cycle, then IDLE.
- Accept:
  - In IDLE with start=1 and op a valid divide code, latch op, a, b and the signed flag (DIV/REM).
  - start with any other op code is ignored and does nothing.
  - start while not IDLE is ignored; upstream holds it via stall.
- Special cases, decided at accept and going IDLE→DONE next cycle (latency 1):
  - b==0: quotient=0xFFFFFFFF, remainder=a.
  - Signed with a==0x80000000 and b==0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Normal path:
  - Signed ops: work on magnitudes |a| and |b|. Record q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
  - Each CALC cycle: shift {rem,quo} left 1, trial-subtract |b| from rem. If non-negative, keep the difference and set quo[0]=1.
  - The counter counts 0..XLEN-1, then goes to FIX.
  - FIX negates the quotient if q_neg and the remainder if r_neg (remainder takes the dividend's sign), then goes to DONE.
  - Latency: start accepted in cycle T; done=1 at T+XLEN+2 (T+34 for XLEN=32).
- Result select: result = quotient for DIV/DIVU, remainder for REM/REMU. Registered; updates only in the cycle done rises.
- flush: in any state, next state=IDLE, busy=0, done=0, result unchanged. flush beats a same-cycle start.
- Reset mid-CALC: everything returns to reset values immediately. No done pulse.
- Unsigned ops: magnitudes are the raw operands; no sign fix. Bit 31 is treated as magnitude.

Decomposition:
- Shared package (cpu_pkg) holds the ALUControl localparams: ALU_AND 0000, ALU_OR 0001, ALU_ADD 0010, ALU_XOR 0011, ALU_SLL 0100, ALU_SLT 0101, ALU_SUB 0110, ALU_MUL 1010, ALU_DIV 1011, ALU_DIVU 1100, ALU_REM 1101, ALU_REMU 1110. It also holds the div_unit state encoding. ALU and div_unit share it.
- One natural sub-module: div_step. It is combinational: one shift/trial-subtract iteration taking rem, quo and divisor, returning next rem and next quo. It is instantiated once in div_unit.

Test Plan:
- DIVU a=100, b=7 → done at T+34, result=14; repeat with REMU → result=2; busy high T+1..T+34.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); DIV a=7, b=0xFFFFFFFE → 0xFFFFFFFD.
- Divide by zero: DIV a=0x12345678, b=0 → result 0xFFFFFFFF at T+1; REMU same operands → 0x12345678.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at T+1; REM → 0.
- Reset asserted at T+10 of DIVU 0xFFFFFFFF/3 → busy=0, done=0, result=0 immediately. A new DIVU 0xFFFFFFFF/3 after release → 0x55555555.
- flush at T+5, with start held high the same cycle and on the following cycles → returns to IDLE with no done pulse and the prior result retained; the next cycle's start is accepted. A second start during CALC is ignored and the original result is delivered.
